// File: rtl/universal_mod_counter_pkg.sv
// Shared encodings for the universal modulo counter: count direction and bound mode.
package universal_mod_counter_pkg;

  typedef enum logic {
    DirDn = 1'b0,
    DirUp = 1'b1
  } dir_e;

  typedef enum logic {
    ModeWrap = 1'b0,
    ModeSat  = 1'b1
  } mode_e;

endpackage

// File: rtl/univ_cnt_prescaler.sv
// Enable prescaler for universal_mod_counter. Built only with UNIV_CNT_PRESCALE_EN defined.
// tick is high on every (div+1)-th enabled cycle; the phase holds while en is low.
`ifdef UNIV_CNT_PRESCALE_EN
module univ_cnt_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a smaller div written mid-phase never strands the counter.
  assign tick = en & (cnt_q >= div);

  // Next phase: clear on request, advance while enabled, hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/universal_mod_counter.sv
// Universal modulo counter: programmable limit, step and wrap/saturate mode, with registered
// wrap pulse and sticky saturate flag. Optional enable prescaler under UNIV_CNT_PRESCALE_EN.
module universal_mod_counter
  import universal_mod_counter_pkg::*;
#(
  parameter int unsigned  N         = 8,
  parameter logic [N-1:0] LIMIT_RST = {N{1'b1}},
  parameter int unsigned  PRESC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [N-1:0]       limit_in,
  input  logic               sat_mode,
  input  logic               syn_clr,
  input  logic               load,
  input  logic [N-1:0]       d,
  input  logic               en,
  input  logic               up,
  input  logic [N-1:0]       step,
`ifdef UNIV_CNT_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [N-1:0]       q,
  output logic               max_tick,
  output logic               min_tick,
  output logic               wrap,
  output logic               sat
);

  if (N < 2) begin : g_n_chk
    $error("universal_mod_counter: N must be at least 2");
  end
  if (PRESC_W < 1) begin : g_presc_chk
    $error("universal_mod_counter: PRESC_W must be at least 1");
  end

  localparam logic [N:0] One = (N+1)'(1);

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] limit_q, limit_d;
  mode_e        mode_q, mode_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;
  logic         tick;

`ifdef UNIV_CNT_PRESCALE_EN
  univ_cnt_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (syn_clr | load),
    .en   (en),
    .div  (presc_div),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  logic [N-1:0] limit_eff, step_eff;
  logic [N:0]   q_w, lim_w, step_w, sum_w;

  // Next-state: config registers, count arithmetic (N+1 bits, no overflow) and event flags.
  always_comb begin
    limit_eff = cfg_we ? limit_in : limit_q;
    mode_d    = cfg_we ? mode_e'(sat_mode) : mode_q;
    limit_d   = limit_eff;
    step_eff  = (step > limit_eff) ? limit_eff : step;
    q_w       = {1'b0, cnt_q};
    lim_w     = {1'b0, limit_eff};
    step_w    = {1'b0, step_eff};
    sum_w     = q_w + step_w;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    sat_d     = sat_q;

    if (syn_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (load) begin
      cnt_d = (d > limit_eff) ? limit_eff : d;
    end else if (cfg_we && (cnt_q > limit_in)) begin
      cnt_d = limit_in;
    end else if (en && tick && (step != '0)) begin
      if (limit_eff == '0) begin
        // Modulus 1: every enabled count is a bound event, q stays 0.
        cnt_d = '0;
        if (mode_d == ModeSat) sat_d = 1'b1;
        else                   wrap_d = 1'b1;
      end else if (dir_e'(up) == DirUp) begin
        if (sum_w <= lim_w) begin
          cnt_d = sum_w[N-1:0];
        end else if (mode_d == ModeSat) begin
          cnt_d = limit_eff;
          sat_d = 1'b1;
        end else begin
          cnt_d  = N'(sum_w - (lim_w + One));
          wrap_d = 1'b1;
        end
      end else begin
        if (q_w >= step_w) begin
          cnt_d = N'(q_w - step_w);
        end else if (mode_d == ModeSat) begin
          cnt_d = '0;
          sat_d = 1'b1;
        end else begin
          cnt_d  = N'(q_w + lim_w + One - step_w);
          wrap_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      limit_q <= LIMIT_RST;
      mode_q  <= ModeWrap;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign q        = cnt_q;
  assign max_tick = (cnt_q == limit_q);
  assign min_tick = (cnt_q == '0);
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_universal_mod_counter.sv
// Self-checking bench for universal_mod_counter (N=4). Honours UNIV_CNT_PRESCALE_EN.
module tb_universal_mod_counter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, cfg_we, sat_mode, syn_clr, load, en, up;
  logic [N-1:0] limit_in, d, step;
  logic [7:0] presc_div;
  logic [N-1:0] q;
  logic       max_tick, min_tick, wrap, sat;

  int n_checks = 0;
  int n_errors = 0;

  universal_mod_counter #(
    .N        (N),
    .LIMIT_RST(4'hF),
    .PRESC_W  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .limit_in (limit_in),
    .sat_mode (sat_mode),
    .syn_clr  (syn_clr),
    .load     (load),
    .d        (d),
    .en       (en),
    .up       (up),
    .step     (step),
`ifdef UNIV_CNT_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .q        (q),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .wrap     (wrap),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  // Reference model: state as plain integers, updated from the behavioural rules.
  int m_q, m_lim, m_mode, m_wrap, m_sat;
`ifdef UNIV_CNT_PRESCALE_EN
  int m_ph;
`endif

  always @(posedge clk) begin : model
    int lim, se, sm;
    bit tk;
    if (!reset) begin
      m_q = 0; m_lim = 15; m_mode = 0; m_wrap = 0; m_sat = 0;
`ifdef UNIV_CNT_PRESCALE_EN
      m_ph = 0;
`endif
    end else begin
      lim = cfg_we ? int'(limit_in) : m_lim;
      sm  = cfg_we ? int'(sat_mode) : m_mode;
`ifdef UNIV_CNT_PRESCALE_EN
      tk = en && (m_ph >= int'(presc_div));
`else
      tk = en;
`endif
      m_wrap = 0;
      if (syn_clr) begin
        m_q = 0; m_sat = 0;
      end else if (load) begin
        m_q = (int'(d) > lim) ? lim : int'(d);
      end else if (cfg_we && m_q > int'(limit_in)) begin
        m_q = int'(limit_in);
      end else if (tk && step != 0) begin
        se = (int'(step) < lim) ? int'(step) : lim;
        if (lim == 0) begin
          if (sm != 0) m_sat = 1; else m_wrap = 1;
        end else if (up) begin
          if (m_q + se <= lim) m_q = m_q + se;
          else if (sm != 0) begin m_q = lim; m_sat = 1; end
          else begin m_q = m_q + se - (lim + 1); m_wrap = 1; end
        end else begin
          if (m_q >= se) m_q = m_q - se;
          else if (sm != 0) begin m_q = 0; m_sat = 1; end
          else begin m_q = m_q + (lim + 1) - se; m_wrap = 1; end
        end
      end
`ifdef UNIV_CNT_PRESCALE_EN
      if (syn_clr || load) m_ph = 0;
      else if (en)         m_ph = tk ? 0 : m_ph + 1;
`endif
      m_lim  = lim;
      m_mode = sm;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(posedge clk) begin
    #1;
    chk("m_q",    32'(q),        32'(m_q));
    chk("m_max",  32'(max_tick), 32'(m_q == m_lim));
    chk("m_min",  32'(min_tick), 32'(m_q == 0));
    chk("m_wrap", 32'(wrap),     32'(m_wrap));
    chk("m_sat",  32'(sat),      32'(m_sat));
  end

  task automatic edge_chk();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int t2q[5] = '{3, 6, 9, 2, 5};
  int t2w[5] = '{0, 0, 0, 1, 0};
`ifdef UNIV_CNT_PRESCALE_EN
  int t6q[6] = '{0, 0, 1, 1, 1, 2};
`endif

  initial begin
    reset = 0; cfg_we = 0; limit_in = 0; sat_mode = 0; syn_clr = 0;
    load = 1; d = 5; en = 0; up = 1; step = 0; presc_div = 0;

    // 1. Reset dominates load.
    repeat (2) edge_chk();
    chk("rst_q", 32'(q), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_min", 32'(min_tick), 1);
    @(negedge clk); reset = 1; d = 15;
    edge_chk(); chk("rst_limit15", 32'(q), 15); chk("rst_max", 32'(max_tick), 1);
    @(negedge clk); load = 0; syn_clr = 1;
    edge_chk(); chk("clr_q", 32'(q), 0);

    // 2. Wrap mode, limit 9, step 3.
    @(negedge clk); syn_clr = 0; cfg_we = 1; limit_in = 9; sat_mode = 0;
    edge_chk(); chk("cfg_q", 32'(q), 0);
    @(negedge clk); cfg_we = 0; en = 1; up = 1; step = 3;
    for (int i = 0; i < 5; i++) begin
      edge_chk();
      chk("up_wrap_q", 32'(q), 32'(t2q[i]));
      chk("up_wrap_w", 32'(wrap), 32'(t2w[i]));
    end
    @(negedge clk); up = 0;
    edge_chk(); chk("dn_q", 32'(q), 2);
    edge_chk(); chk("dn_wrap_q", 32'(q), 9); chk("dn_wrap_w", 32'(wrap), 1);

    // 3. Saturate mode.
    @(negedge clk); en = 0; cfg_we = 1; sat_mode = 1; load = 1; d = 8;
    edge_chk(); chk("sat_load", 32'(q), 8);
    @(negedge clk); cfg_we = 0; load = 0; en = 1; up = 1; step = 4;
    edge_chk(); chk("sat_up_q", 32'(q), 9); chk("sat_up_s", 32'(sat), 1);
    @(negedge clk); up = 0;
    edge_chk(); chk("sat_dn1", 32'(q), 5);
    edge_chk(); chk("sat_dn2", 32'(q), 1);
    edge_chk(); chk("sat_dn3", 32'(q), 0); chk("sat_sticky", 32'(sat), 1);
    @(negedge clk); en = 0; syn_clr = 1;
    edge_chk(); chk("sat_clr", 32'(sat), 0);

    // 4. Simultaneous events and clamps.
    @(negedge clk); syn_clr = 0; load = 1; d = 5;
    edge_chk(); chk("ld5", 32'(q), 5);
    @(negedge clk); syn_clr = 1; d = 7; en = 1; up = 1; step = 1;
    edge_chk(); chk("clr_prio", 32'(q), 0);
    @(negedge clk); syn_clr = 0; en = 0; d = 14;
    edge_chk(); chk("ld_clamp", 32'(q), 9);
    @(negedge clk); load = 0; cfg_we = 1; limit_in = 4;
    edge_chk(); chk("cfg_clamp", 32'(q), 4); chk("cfg_max", 32'(max_tick), 1);
    @(negedge clk); limit_in = 9; sat_mode = 0; load = 1; d = 0;
    edge_chk(); chk("ld0", 32'(q), 0);
    @(negedge clk); cfg_we = 0; load = 0; en = 1; step = 12;
    edge_chk(); chk("bigstep1", 32'(q), 9);
    edge_chk(); chk("bigstep2", 32'(q), 8); chk("bigstep_w", 32'(wrap), 1);

    // 5. limit 0, step 0, reset during wrap.
    @(negedge clk); en = 0; cfg_we = 1; limit_in = 0;
    edge_chk(); chk("lim0_clamp", 32'(q), 0);
    @(negedge clk); cfg_we = 0; en = 1; step = 1;
    repeat (3) begin
      edge_chk(); chk("lim0_q", 32'(q), 0); chk("lim0_w", 32'(wrap), 1);
    end
    @(negedge clk); step = 0;
    edge_chk(); chk("step0_q", 32'(q), 0); chk("step0_w", 32'(wrap), 0);
    @(negedge clk); step = 1;
    edge_chk(); chk("lim0_w2", 32'(wrap), 1);
    @(negedge clk); reset = 0;
    edge_chk(); chk("rst_wrap_kill", 32'(wrap), 0);
    @(negedge clk); reset = 1; cfg_we = 1; limit_in = 0; sat_mode = 1;
    edge_chk(); chk("lim0_sat", 32'(sat), 1); chk("lim0_sat_q", 32'(q), 0);
    @(negedge clk); cfg_we = 0; en = 0; syn_clr = 1;
    edge_chk();
    @(negedge clk); syn_clr = 0; cfg_we = 1; limit_in = 15; sat_mode = 0;
    edge_chk(); chk("restore_max", 32'(max_tick), 0);
    @(negedge clk); cfg_we = 0;

`ifdef UNIV_CNT_PRESCALE_EN
    // 6. Prescaler: divide by 3, hold phase while disabled, load clears phase.
    @(negedge clk); presc_div = 2; en = 1; up = 1; step = 1;
    for (int i = 0; i < 6; i++) begin
      edge_chk(); chk("presc_q", 32'(q), 32'(t6q[i]));
    end
    edge_chk(); chk("presc_ph1", 32'(q), 2);
    @(negedge clk); en = 0;
    repeat (2) edge_chk();
    chk("presc_hold", 32'(q), 2);
    @(negedge clk); en = 1;
    edge_chk(); chk("presc_resume1", 32'(q), 2);
    edge_chk(); chk("presc_resume2", 32'(q), 3);
    edge_chk();
    @(negedge clk); load = 1; d = 0;
    edge_chk(); chk("presc_ld", 32'(q), 0);
    @(negedge clk); load = 0;
    edge_chk(); chk("presc_ld1", 32'(q), 0);
    edge_chk(); chk("presc_ld2", 32'(q), 0);
    edge_chk(); chk("presc_ld3", 32'(q), 1);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
